adc_scan_ctrl: RTL and testbench

ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

---
 rtl/adc_scan_pkg.sv | 28 ++
 rtl/adc_scan_ctrl_regfile.sv | 44 ++++
 rtl/adc_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the ADC scan controller.
package adc_scan_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_START,
    S_SETTLE,
    S_WAIT_EOC,
    S_READ,
    S_STORE
  } state_e;

  // Lowest set bit of m as {found, index}; index is 0 when nothing is set.
  function automatic logic [CH_W:0] first_set(input logic [NUM_CH-1:0] m);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_scan_ctrl_regfile.sv
// Result store: one entry plus valid bit per channel, combinational read.
// With ADC_SCAN_AVG_EN defined, a write to an already-valid entry stores the
// truncated mean of the old and new samples.
module adc_result_regfile
  import adc_scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [CH_W-1:0]   rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  logic [DATA_W-1:0] mem_q [NUM_CH];
  logic [NUM_CH-1:0] vld_q;
  logic [DATA_W-1:0] wr_val_c;

`ifdef ADC_SCAN_AVG_EN
  // Average with a 9-bit sum so the carry is kept before halving.
  assign wr_val_c = vld_q[wr_addr_i]
                  ? DATA_W'(({1'b0, mem_q[wr_addr_i]} + {1'b0, wr_data_i}) >> 1)
                  : wr_data_i;
`else
  assign wr_val_c = wr_data_i;
`endif

  // Entry and valid-bit update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) mem_q[i] <= '0;
      vld_q <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_val_c;
      vld_q[wr_addr_i] <= 1'b1;
    end
  end

  assign rd_data_o  = mem_q[rd_addr_i];
  assign rd_valid_o = vld_q[rd_addr_i];

endmodule

// File: rtl/adc_scan_ctrl.sv
// ADC channel scan controller: sequences ALE/START/EOC/OE handshakes over the
// enabled channels and keeps the latest result per channel.
// Optional averaging of results is enabled by defining ADC_SCAN_AVG_EN.
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned SETTLE_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_en,
  input  logic              trig,
  input  logic [NUM_CH-1:0] chan_mask,
  input  logic              adc_eoc,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_ale,
  output logic              adc_start,
  output logic              adc_oe,
  output logic [CH_W-1:0]   adc_addr,
  input  logic [CH_W-1:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              scan_done,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state_q;
  logic [NUM_CH-1:0] mask_q;
  logic [CH_W-1:0]   ch_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] sample_q;
  logic              ale_q, start_q, oe_q, busy_q, done_q, terr_q;

  logic [NUM_CH-1:0] above_c;
  logic [CH_W:0]     nxt_c, first_c;
  logic              tmo_c, adv_c, restart_c;

  // Channel search: next enabled channel above the current one, and the
  // first enabled channel of a fresh mask.
  assign above_c   = mask_q & ~((NUM_CH'(2) << ch_q) - NUM_CH'(1));
  assign nxt_c     = first_set(above_c);
  assign first_c   = first_set(chan_mask);
  assign tmo_c     = (state_q == S_WAIT_EOC) && !adc_eoc
                     && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign adv_c     = tmo_c || (state_q == S_STORE);
  assign restart_c = scan_en && first_c[CH_W];

  // Scan sequencer with registered strobes and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      sample_q <= '0;
      ale_q    <= 1'b0;
      start_q  <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      ale_q   <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;

      if (tmo_c)        terr_q <= 1'b1;
      else if (err_clr) terr_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if ((scan_en || trig) && first_c[CH_W]) begin
            mask_q  <= chan_mask;
            ch_q    <= first_c[CH_W-1:0];
            ale_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          start_q <= 1'b1;
          state_q <= S_START;
        end
        S_START: begin
          cnt_q   <= '0;
          state_q <= (SETTLE_CYC == 0) ? S_WAIT_EOC : S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
            cnt_q   <= '0;
            state_q <= S_WAIT_EOC;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_EOC: begin
          if (adc_eoc) begin
            oe_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_READ;
          end else if (!tmo_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_READ: begin
          if (cnt_q == '0) begin
            cnt_q <= CNT_W'(1);
          end else begin
            sample_q <= adc_data;
            oe_q     <= 1'b0;
            state_q  <= S_STORE;
          end
        end
        S_STORE: begin
        end
        default: state_q <= S_IDLE;
      endcase

      // End of a conversion (stored or timed out): next channel or scan end.
      if (adv_c) begin
        if (nxt_c[CH_W]) begin
          ch_q    <= nxt_c[CH_W-1:0];
          ale_q   <= 1'b1;
          state_q <= S_ADDR;
        end else begin
          done_q <= 1'b1;
          if (restart_c) begin
            mask_q  <= chan_mask;
            ch_q    <= first_c[CH_W-1:0];
            ale_q   <= 1'b1;
            state_q <= S_ADDR;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      end
    end
  end

  adc_result_regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (state_q == S_STORE),
    .wr_addr_i  (ch_q),
    .wr_data_i  (sample_q),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid)
  );

  assign adc_ale     = ale_q;
  assign adc_start   = start_q;
  assign adc_oe      = oe_q;
  assign adc_addr    = ch_q;
  assign busy        = busy_q;
  assign scan_done   = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Self-checking bench for adc_scan_ctrl: a timeline model of each scan
// predicts strobes, status and the result store on every cycle.
module tb_adc_scan_ctrl;

  localparam int unsigned TO     = 64;
  localparam int unsigned SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst, scan_en, trig, err_clr, adc_eoc;
  logic [7:0] chan_mask, adc_data;
  logic [2:0] rd_addr;
  logic       adc_ale, adc_start, adc_oe;
  logic [2:0] adc_addr;
  logic [7:0] rd_data;
  logic       rd_valid, busy, scan_done, timeout_err;

  always #5 clk = ~clk;

  adc_scan_ctrl #(.TIMEOUT_CYC(TO), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .trig(trig), .chan_mask(chan_mask),
    .adc_eoc(adc_eoc), .adc_data(adc_data), .adc_ale(adc_ale), .adc_start(adc_start),
    .adc_oe(adc_oe), .adc_addr(adc_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .scan_done(scan_done),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model state
  logic [7:0] mem [8];
  bit         vld [8];
  bit   [7:0] dval [8];
  logic [2:0] exp_addr;
  bit         exp_done, exp_terr;
  int         force_rd = -1;
  int         dir_d = 1;
  int         rst_ch = -1;
  int         cur_scan = 0;
  int         drop_scan = 1000;
  int         drop_ch = 0;
  bit         force_to, clr_collide, rnd_to, rnd_data, rnd_mask, rnd_trig;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      mem[i] = 8'h00;
      vld[i] = 1'b0;
    end
    exp_addr = 3'd0;
    exp_done = 1'b0;
    exp_terr = 1'b0;
  endfunction

  // One cycle: compare every output against the model at the falling edge.
  task automatic step(input bit e_ale, input bit e_start, input bit e_oe, input bit e_busy);
    @(negedge clk);
    chk("adc_ale", 32'(adc_ale), 32'(e_ale));
    chk("adc_start", 32'(adc_start), 32'(e_start));
    chk("adc_oe", 32'(adc_oe), 32'(e_oe));
    chk("adc_addr", 32'(adc_addr), 32'(exp_addr));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("scan_done", 32'(scan_done), 32'(exp_done));
    chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
    exp_done = 1'b0;
    trig     = 1'b0;
    err_clr  = 1'b0;
    rd_addr  = (force_rd >= 0) ? 3'(force_rd) : 3'($urandom_range(0, 7));
    #1;
    chk("rd_data", 32'(rd_data), 32'(mem[rd_addr]));
    chk("rd_valid", 32'(rd_valid), 32'(vld[rd_addr]));
  endtask

  // One conversion on channel ch; d = WAIT_EOC cycles before eoc, tmo = never assert eoc.
  task automatic conv(input int ch, input bit tmo, input int d, output bit ab);
    ab = 1'b0;
    exp_addr = 3'(ch);
    step(1, 0, 0, 1);
    if (cur_scan >= drop_scan && ch >= drop_ch) scan_en = 1'b0;
    if (rnd_mask && $urandom_range(0, 3) == 0) chan_mask = 8'($urandom);
    if (rnd_trig) trig = 1'($urandom_range(0, 1));
    adc_eoc = 1'($urandom_range(0, 1));
    step(0, 1, 0, 1);
    adc_eoc = 1'($urandom_range(0, 1));
    for (int i = 0; i < int'(SETTLE); i++) begin
      step(0, 0, 0, 1);
      adc_eoc = 1'($urandom_range(0, 1));
    end
    if (tmo) begin
      for (int i = 0; i < int'(TO); i++) begin
        step(0, 0, 0, 1);
        adc_eoc = 1'b0;
        if (i == int'(TO) - 1 && clr_collide) err_clr = 1'b1;
      end
      exp_terr = 1'b1;
      return;
    end
    for (int i = 0; i <= d; i++) begin
      step(0, 0, 0, 1);
      adc_eoc = (i == d);
    end
    step(0, 0, 1, 1);
    adc_eoc  = 1'($urandom_range(0, 1));
    adc_data = 8'($urandom);
    if (rst_ch == ch) begin
      rst = 1'b1;
      scan_en = 1'b0;
      trig = 1'b0;
      #1;
      model_reset();
      step(0, 0, 0, 0);
      rst = 1'b0;
      ab = 1'b1;
      return;
    end
    step(0, 0, 1, 1);
    adc_data = dval[ch];
    force_rd = ch;
    step(0, 0, 0, 1);
    force_rd = -1;
    adc_data = 8'($urandom);
`ifdef ADC_SCAN_AVG_EN
    if (vld[ch]) mem[ch] = 8'((9'(mem[ch]) + 9'(dval[ch])) >> 1);
    else         mem[ch] = dval[ch];
`else
    mem[ch] = dval[ch];
`endif
    vld[ch] = 1'b1;
  endtask

  // Scans back to back while scan_en stays high; mask sampled at each scan start.
  task automatic run_scans(output bit ab);
    bit [7:0] lm;
    lm = chan_mask;
    ab = 1'b0;
    cur_scan = 0;
    forever begin
      for (int ch = 0; ch < 8; ch++) begin
        if (lm[ch]) begin
          bit tmo;
          int d;
          tmo = force_to;
          d   = dir_d;
          if (rnd_to) begin
            tmo = ($urandom_range(0, 15) == 0);
            d   = ($urandom_range(0, 9) == 0) ? int'(TO) - 1 : int'($urandom_range(0, 4));
          end
          if (rnd_data) dval[ch] = 8'($urandom);
          conv(ch, tmo, d, ab);
          if (ab) return;
        end
      end
      exp_done = 1'b1;
      cur_scan++;
      if (!(scan_en && chan_mask != 8'h00)) return;
      lm = chan_mask;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ab;
    rst = 1'b1; scan_en = 1'b0; trig = 1'b0; err_clr = 1'b0; adc_eoc = 1'b0;
    chan_mask = 8'h00; adc_data = 8'h00; rd_addr = 3'd0;
    force_to = 0; clr_collide = 0; rnd_to = 0; rnd_data = 0; rnd_mask = 0; rnd_trig = 0;
    for (int i = 0; i < 8; i++) dval[i] = 8'h00;
    model_reset();

    // Reset values
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0);

    // Timeout on ch0, then err_clr
    chan_mask = 8'h01; trig = 1'b1; force_to = 1'b1;
    run_scans(ab);
    force_to = 1'b0;
    force_rd = 0;
    step(0, 0, 0, 0);
    chk("lit_terr_set", 32'(timeout_err), 32'd1);
    chk("lit_valid0_after_timeout", 32'(rd_valid), 32'd0);
    force_rd = -1;
    err_clr = 1'b1; exp_terr = 1'b0;
    step(0, 0, 0, 0);
    chk("lit_terr_cleared", 32'(timeout_err), 32'd0);

    // Empty mask: trig and scan_en must not start anything
    chan_mask = 8'h00; trig = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    scan_en = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    scan_en = 1'b0;
    step(0, 0, 0, 0);

    // Mask 0x05 single scan with trig pulses while busy
    chan_mask = 8'h05; dval[0] = 8'h11; dval[2] = 8'h33; trig = 1'b1; rnd_trig = 1'b1;
    run_scans(ab);
    rnd_trig = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    force_rd = 0; step(0, 0, 0, 0);
    chk("lit_rd_ch0", 32'(rd_data), 32'h11);
    force_rd = 2; step(0, 0, 0, 0);
    chk("lit_rd_ch2", 32'(rd_data), 32'h33);
    force_rd = 1; step(0, 0, 0, 0);
    chk("lit_valid_ch1", 32'(rd_valid), 32'd0);
    force_rd = -1;

    // Two samples on ch1
    chan_mask = 8'h02; dval[1] = 8'h80; trig = 1'b1;
    run_scans(ab);
    force_rd = 1; step(0, 0, 0, 0);
    chk("lit_ch1_first", 32'(rd_data), 32'h80);
    force_rd = -1;
    dval[1] = 8'h41; trig = 1'b1;
    run_scans(ab);
    force_rd = 1; step(0, 0, 0, 0);
`ifdef ADC_SCAN_AVG_EN
    chk("lit_ch1_second", 32'(rd_data), 32'h60);
`else
    chk("lit_ch1_second", 32'(rd_data), 32'h41);
`endif
    force_rd = -1;

    // eoc on the very last WAIT_EOC cycle is not a timeout
    chan_mask = 8'h10; dval[4] = 8'h5A; dir_d = int'(TO) - 1; trig = 1'b1;
    run_scans(ab);
    dir_d = 1;
    step(0, 0, 0, 0);
    chk("lit_no_timeout_at_edge", 32'(timeout_err), 32'd0);

    // Continuous 0xFF scans, scan_en dropped at ch3 of the third scan
    scan_en = 1'b1; chan_mask = 8'hFF; rnd_data = 1'b1; drop_scan = 2; drop_ch = 3;
    run_scans(ab);
    chk("lit_three_scans", 32'(cur_scan), 32'd3);
    step(0, 0, 0, 0);
    drop_scan = 1000;

    // Timeout coinciding with err_clr keeps the flag
    chan_mask = 8'h01; force_to = 1'b1; clr_collide = 1'b1; trig = 1'b1;
    run_scans(ab);
    force_to = 1'b0; clr_collide = 1'b0;
    step(0, 0, 0, 0);
    chk("lit_terr_collide", 32'(timeout_err), 32'd1);
    err_clr = 1'b1; exp_terr = 1'b0;
    step(0, 0, 0, 0);

    // Randomized continuous scanning
    scan_en = 1'b1; chan_mask = 8'($urandom_range(1, 255));
    rnd_to = 1'b1; rnd_mask = 1'b1; rnd_trig = 1'b1; drop_scan = 20; drop_ch = 0;
    run_scans(ab);
    rnd_to = 1'b0; rnd_mask = 1'b0; rnd_trig = 1'b0; drop_scan = 1000;
    scan_en = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Reset during READ on ch4
    chan_mask = 8'h30 | 8'($urandom); rst_ch = 4; trig = 1'b1;
    run_scans(ab);
    chk("lit_reset_abort", 32'(ab), 32'd1);
    rst_ch = -1;
    for (int i = 0; i < 8; i++) begin
      force_rd = i;
      step(0, 0, 0, 0);
      chk("lit_valid_after_rst", 32'(rd_valid), 32'd0);
    end
    force_rd = -1;

    // First post-reset scan starts at the lowest enabled channel
    chan_mask = 8'h0A; trig = 1'b1;
    run_scans(ab);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
